// File: rtl/lsc_gain_sched.sv
// -----------------------------------------------------------------------------
// lsc_gain_sched
//
// Frame-level sequencer for the lens-shading-correction pipeline. It takes a
// raster-order RGB pixel stream from demosaic, tracks the pixel x/y position,
// looks up the Q4.8 gain triple of the grid block that contains the pixel, and
// hands pixel + gain to the LSC multiply stage as one registered beat. The gain
// grid is loadable only while idle, so it stays frozen for a whole frame.
//
// Optional feature macro: LSC_BYPASS_EN
//   When defined, adds a 'bypass' input. It is sampled on the accepted start
//   pulse; while the captured value is 1, every beat carries unity gain.
//
// Ports
//   clock       sole clock, all state updates on posedge
//   reset       synchronous active-high reset
//   bypass      (LSC_BYPASS_EN only) per-frame unity-gain select
//   start       one-cycle pulse, begins a frame when idle
//   cfg_we      gain-table write strobe (honoured only when idle)
//   cfg_addr    gain-table index = row*GRID_COLS + col
//   cfg_data    {R,G,B} Q4.8 gains
//   u_i_ready   upstream pixel valid
//   data_in     {R,G,B} pixel
//   i_i_ready   block accepts a pixel this cycle (combinational)
//   u_r_ready   downstream accepts the output beat
//   i_r_ready   output beat valid
//   data_out    registered pixel
//   gain_out    registered gain triple for that pixel
//   busy        block is in a frame
//   frame_done  one-cycle pulse after the last beat has left
// -----------------------------------------------------------------------------
module lsc_gain_sched #(
    parameter int DATA_WIDTH = 12,
    parameter int IMG_W      = 320,
    parameter int IMG_H      = 240,
    parameter int GRID_SHIFT = 5,
    parameter int GRID_COLS  = 10,
    parameter int GRID_ROWS  = 8
) (
    input  logic                    clock,
    input  logic                    reset,
`ifdef LSC_BYPASS_EN
    input  logic                    bypass,
`endif
    input  logic                    start,
    input  logic                    cfg_we,
    input  logic [6:0]              cfg_addr,
    input  logic [3*DATA_WIDTH-1:0] cfg_data,
    input  logic                    u_i_ready,
    input  logic [3*DATA_WIDTH-1:0] data_in,
    output logic                    i_i_ready,
    input  logic                    u_r_ready,
    output logic                    i_r_ready,
    output logic [3*DATA_WIDTH-1:0] data_out,
    output logic [3*DATA_WIDTH-1:0] gain_out,
    output logic                    busy,
    output logic                    frame_done
);

    localparam int PIX_W       = 3 * DATA_WIDTH;
    localparam int NUM_ENTRIES = GRID_COLS * GRID_ROWS;
    localparam int IDX_W       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
    localparam int X_W         = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int Y_W         = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    // Q4.8 unity gain (1.0 = 256) replicated for R, G and B.
    localparam logic [DATA_WIDTH-1:0] UNITY_CH = DATA_WIDTH'(256);
    localparam logic [PIX_W-1:0]      UNITY    = {3{UNITY_CH}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t             state_r;
    logic [X_W-1:0]     x_r;
    logic [Y_W-1:0]     y_r;
    logic               i_r_ready_r;
    logic [PIX_W-1:0]   data_out_r;
    logic [PIX_W-1:0]   gain_out_r;
    logic               busy_r;
    logic               frame_done_r;
    logic [PIX_W-1:0]   gain_tbl_r [NUM_ENTRIES];
`ifdef LSC_BYPASS_EN
    logic               bypass_r;
`endif

    logic               i_i_ready_s;
    logic               insert_s;
    logic               last_col_s;
    logic               last_row_s;
    logic [IDX_W-1:0]   gain_idx_s;
    logic [IDX_W-1:0]   wr_idx_s;
    logic               wr_ok_s;
    logic [PIX_W-1:0]   sel_gain_s;

    // A new pixel may enter whenever the output slot is empty or is being
    // emptied this same cycle, giving one pixel per cycle at full rate.
    assign i_i_ready_s = (state_r == ST_RUN) && (!i_r_ready_r || u_r_ready);
    assign insert_s    = u_i_ready && i_i_ready_s;
    assign last_col_s  = (x_r == X_W'(IMG_W - 1));
    assign last_row_s  = (y_r == Y_W'(IMG_H - 1));

    // Block index of the current pixel; a partial edge block falls into the
    // last column/row entry because the grid is ceil-sized.
    assign gain_idx_s  = IDX_W'(y_r >> GRID_SHIFT) * IDX_W'(GRID_COLS)
                       + IDX_W'(x_r >> GRID_SHIFT);

    assign wr_idx_s    = IDX_W'(cfg_addr);
    assign wr_ok_s     = (state_r == ST_IDLE) && cfg_we
                       && (cfg_addr < 7'(NUM_ENTRIES));

    // Gain presented with the next beat: table entry, or unity when bypassed.
    always_comb begin
        sel_gain_s = gain_tbl_r[gain_idx_s];
`ifdef LSC_BYPASS_EN
        if (bypass_r) begin
            sel_gain_s = UNITY;
        end else begin
            sel_gain_s = gain_tbl_r[gain_idx_s];
        end
`endif
    end

    // Gain table: reset to unity, writable only while idle.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                gain_tbl_r[i] <= UNITY;
            end
        end else if (wr_ok_s) begin
            gain_tbl_r[wr_idx_s] <= cfg_data;
        end
    end

    // Frame sequencer: position counters, output beat register and status.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            x_r          <= {X_W{1'b0}};
            y_r          <= {Y_W{1'b0}};
            i_r_ready_r  <= 1'b0;
            data_out_r   <= {PIX_W{1'b0}};
            gain_out_r   <= {PIX_W{1'b0}};
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
`ifdef LSC_BYPASS_EN
            bypass_r     <= 1'b0;
`endif
        end else begin
            frame_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r <= ST_RUN;
                        busy_r  <= 1'b1;
                        x_r     <= {X_W{1'b0}};
                        y_r     <= {Y_W{1'b0}};
`ifdef LSC_BYPASS_EN
                        bypass_r <= bypass;
`endif
                    end
                end
                ST_RUN: begin
                    if (insert_s) begin
                        data_out_r  <= data_in;
                        gain_out_r  <= sel_gain_s;
                        i_r_ready_r <= 1'b1;
                        if (last_col_s) begin
                            x_r <= {X_W{1'b0}};
                            if (last_row_s) begin
                                y_r     <= {Y_W{1'b0}};
                                state_r <= ST_DRAIN;
                            end else begin
                                y_r <= y_r + Y_W'(1);
                            end
                        end else begin
                            x_r <= x_r + X_W'(1);
                        end
                    end else if (i_r_ready_r && u_r_ready) begin
                        i_r_ready_r <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    // Finish once the final beat has been taken (or none is held).
                    if (!i_r_ready_r || u_r_ready) begin
                        i_r_ready_r  <= 1'b0;
                        state_r      <= ST_IDLE;
                        busy_r       <= 1'b0;
                        frame_done_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    busy_r      <= 1'b0;
                    i_r_ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign i_i_ready  = i_i_ready_s;
    assign i_r_ready  = i_r_ready_r;
    assign data_out   = data_out_r;
    assign gain_out   = gain_out_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_lsc_gain_sched.sv
// -----------------------------------------------------------------------------
// tb_lsc_gain_sched
//
// Scoreboard bench for lsc_gain_sched, run on a reduced 36x20 image with
// 8x8 blocks (5x3 grid, partial last column and row). The stimulus side keeps
// its own copy of the gain grid and raster position; every accepted pixel
// pushes the expected {pixel, gain} into a queue, and a separate monitor pops
// and compares whenever a beat leaves the block. The monitor also checks that
// a stalled beat holds still.
// -----------------------------------------------------------------------------
module tb_lsc_gain_sched;

    localparam int DW    = 12;
    localparam int PW    = 3 * DW;
    localparam int W     = 36;
    localparam int H     = 20;
    localparam int GS    = 3;
    localparam int GC    = 5;
    localparam int GR    = 3;
    localparam int NENT  = GC * GR;
    localparam int NPIX  = W * H;
    localparam logic [PW-1:0] UNITY = {12'd256, 12'd256, 12'd256};

    typedef struct {
        logic [PW-1:0] pix;
        logic [PW-1:0] gain;
        int            x;
        int            y;
    } exp_t;

    logic          clock;
    logic          reset;
    logic          start;
    logic          cfg_we;
    logic [6:0]    cfg_addr;
    logic [PW-1:0] cfg_data;
    logic          u_i_ready;
    logic [PW-1:0] data_in;
    logic          i_i_ready;
    logic          u_r_ready;
    logic          i_r_ready;
    logic [PW-1:0] data_out;
    logic [PW-1:0] gain_out;
    logic          busy;
    logic          frame_done;
`ifdef LSC_BYPASS_EN
    logic          bypass;
`endif

    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;
    exp_t          exp_q[$];
    logic [PW-1:0] model_tbl [NENT];
    bit            model_byp = 1'b0;

    lsc_gain_sched #(
        .DATA_WIDTH (DW),
        .IMG_W      (W),
        .IMG_H      (H),
        .GRID_SHIFT (GS),
        .GRID_COLS  (GC),
        .GRID_ROWS  (GR)
    ) dut (
        .clock      (clock),
        .reset      (reset),
`ifdef LSC_BYPASS_EN
        .bypass     (bypass),
`endif
        .start      (start),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .u_i_ready  (u_i_ready),
        .data_in    (data_in),
        .i_i_ready  (i_i_ready),
        .u_r_ready  (u_r_ready),
        .i_r_ready  (i_r_ready),
        .data_out   (data_out),
        .gain_out   (gain_out),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic logic [PW-1:0] rnd_pw();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[PW-1:0];
    endfunction

    // Monitor: pops the scoreboard on every beat removal, checks stalls hold.
    initial begin : monitor
        bit            hold_v;
        logic [PW-1:0] hold_d;
        logic [PW-1:0] hold_g;
        exp_t          e;
        hold_v = 1'b0;
        hold_d = '0;
        hold_g = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                hold_v = 1'b0;
            end else begin
                if (hold_v) begin
                    chk("hold_valid", 64'(i_r_ready), 64'd1);
                    chk("hold_data", 64'(data_out), 64'(hold_d));
                    chk("hold_gain", 64'(gain_out), 64'(hold_g));
                end
                if (i_r_ready && u_r_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 64'(data_out), 64'hDEAD);
                    end else begin
                        e = exp_q.pop_front();
                        checks++;
                        if (data_out !== e.pix || gain_out !== e.gain) begin
                            errors++;
                            $display("FAIL beat(%0d,%0d): got pix %h gain %h expected pix %h gain %h",
                                     e.x, e.y, data_out, gain_out, e.pix, e.gain);
                        end
                    end
                end
                hold_v = i_r_ready && !u_r_ready;
                hold_d = data_out;
                hold_g = gain_out;
            end
        end
    end

    task automatic idle_inputs();
        start     = 1'b0;
        cfg_we    = 1'b0;
        cfg_addr  = 7'd0;
        cfg_data  = '0;
        u_i_ready = 1'b0;
        data_in   = '0;
    endtask

    // Synchronous reset for one edge, then check every output at reset value.
    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        u_r_ready = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        exp_q.delete();
        for (int i = 0; i < NENT; i++) model_tbl[i] = UNITY;
        chk("rst_i_i_ready", 64'(i_i_ready), 64'd0);
        chk("rst_i_r_ready", 64'(i_r_ready), 64'd0);
        chk("rst_data_out", 64'(data_out), 64'd0);
        chk("rst_gain_out", 64'(gain_out), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
    endtask

    // Idle-time table write; out-of-range addresses leave the model alone.
    task automatic tbl_write(input int addr, input logic [PW-1:0] d);
        cfg_we   = 1'b1;
        cfg_addr = 7'(addr);
        cfg_data = d;
        @(posedge clock); #1;
        cfg_we   = 1'b0;
        if (addr < NENT) model_tbl[addr] = d;
    endtask

    // One frame. ui/ur are percent chances of upstream valid / downstream
    // ready. abort_at >= 0 resets the block once that many pixels entered.
    task automatic run_frame(input int ui_pct, input int ur_pct, input bit do_stall,
                             input int abort_at, input bit check_time, input bit byp);
        logic [PW-1:0] frame_tbl [NENT];
        int  pushed;
        int  px;
        int  py;
        int  k0;
        int  n;
        int  stall_left;
        bit  stall_now;
        bit  stalled;
        bit  done;
        exp_t e;
        frame_tbl  = model_tbl;
        pushed     = 0;
        px         = 0;
        py         = 0;
        stall_left = 0;
        stalled    = 1'b0;
        done       = 1'b0;
        n          = 0;
`ifdef LSC_BYPASS_EN
        bypass = byp;
`endif
        u_r_ready = 1'b1;
        start     = 1'b1;
        k0        = cyc;
        @(posedge clock); #1;
        start = 1'b0;
`ifdef LSC_BYPASS_EN
        bypass = 1'b0;
`endif
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_i_i_ready", 64'(i_i_ready), 64'd1);
        while (!done && n < NPIX * 20 + 200) begin
            n++;
            if (abort_at >= 0 && pushed == abort_at) begin
                chk("abort_position", 64'(py * W + px), 64'(abort_at));
                do_reset();
                return;
            end
            u_i_ready = (pushed < NPIX) && ($urandom_range(99) < ui_pct);
            data_in   = rnd_pw();
            stall_now = 1'b0;
            if (do_stall && !stalled && pushed == NPIX / 2) begin
                stalled    = 1'b1;
                stall_left = 5;
            end
            if (stall_left > 0) begin
                stall_left--;
                stall_now = 1'b1;
                u_r_ready = 1'b0;
                u_i_ready = 1'b1;
            end else begin
                u_r_ready = ($urandom_range(99) < ur_pct);
            end
            // Mid-frame start pulses and table writes must have no effect.
            start     = (pushed < NPIX) && ($urandom_range(7) == 0);
            cfg_we    = (pushed < NPIX) && ($urandom_range(3) == 0);
            cfg_addr  = 7'($urandom_range(NENT - 1));
            cfg_data  = rnd_pw();
            @(negedge clock);
            if (stall_now) begin
                chk("stall_i_i_ready", 64'(i_i_ready), 64'(exp_q.size() == 0));
            end
            if (u_i_ready && i_i_ready) begin
                e.pix  = data_in;
                e.gain = byp ? UNITY : frame_tbl[(py >> GS) * GC + (px >> GS)];
                e.x    = px;
                e.y    = py;
                exp_q.push_back(e);
                pushed++;
                if (px == W - 1) begin
                    px = 0;
                    py++;
                end else begin
                    px++;
                end
            end
            if (frame_done) begin
                done = 1'b1;
                chk("done_all_pixels_in", 64'(pushed), 64'(NPIX));
                chk("done_queue_empty", 64'(exp_q.size()), 64'd0);
                chk("done_busy_low", 64'(busy), 64'd0);
                if (check_time) chk("frame_cycles", 64'(cyc - k0), 64'(NPIX + 2));
            end
            @(posedge clock); #1;
        end
        idle_inputs();
        if (!done) chk("frame_done_timeout", 64'd0, 64'd1);
        @(posedge clock); #1;
        chk("idle_after_frame", 64'(busy), 64'd0);
    endtask

    initial begin
        reset     = 1'b1;
        u_r_ready = 1'b0;
        idle_inputs();
`ifdef LSC_BYPASS_EN
        bypass = 1'b0;
`endif
        repeat (3) @(posedge clock);
        #1;
        do_reset();

        // Untouched table: unity everywhere, full-rate frame length.
        run_frame(100, 100, 1'b0, -1, 1'b1, 1'b0);

        // Block (1,1) gets {512,384,256}; a few other entries random;
        // out-of-range addresses are dropped.
        tbl_write(1 * GC + 1, {12'd512, 12'd384, 12'd256});
        tbl_write(GC * GR - 1, rnd_pw());
        tbl_write(2, rnd_pw());
        tbl_write(NENT, rnd_pw());
        tbl_write(100, rnd_pw());
        run_frame(100, 100, 1'b1, -1, 1'b0, 1'b0);
        run_frame(70, 70, 1'b1, -1, 1'b0, 1'b0);
        run_frame(50, 85, 1'b0, -1, 1'b0, 1'b0);

        // Abort at pixel (10,5); table returns to unity.
        run_frame(100, 100, 1'b0, 5 * W + 10, 1'b0, 1'b0);
        run_frame(100, 100, 1'b0, -1, 1'b1, 1'b0);

        // Distinct gains per block show the next frame restarts at (0,0).
        for (int i = 0; i < NENT; i++) tbl_write(i, rnd_pw());
        run_frame(100, 100, 1'b0, -1, 1'b1, 1'b0);
        run_frame(80, 60, 1'b1, -1, 1'b0, 1'b0);

`ifdef LSC_BYPASS_EN
        tbl_write(0, {12'd512, 12'd512, 12'd512});
        run_frame(100, 100, 1'b0, -1, 1'b0, 1'b1);
        run_frame(100, 100, 1'b0, -1, 1'b0, 1'b0);
`endif

        repeat (3) @(posedge clock);
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
